// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array host: FSM state encoding and
// buffer sizing helpers used to derive port and counter widths.
package systolic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStream,
    StWaitBusy,
    StWaitIdle,
    StFlush,
    StCollect,
    StDone
  } state_e;

  // Operand words per job: every row and every column consumer gets steps words.
  function automatic int unsigned ops_f(input int unsigned w, input int unsigned h,
                                        input int unsigned s);
    return s * (w + h);
  endfunction

  function automatic int unsigned macs_f(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned clog2_min1_f(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_host_counter.sv
// Saturating up-counter with synchronous clear, used for the operand beat and
// result index so neither can wrap within a job.
module systolic_host_counter #(
  parameter int unsigned Width  = 4,
  parameter int unsigned MaxVal = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] MaxCnt = Width'(MaxVal);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MaxCnt)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/systolic_host.sv
// Host sequencer for a systolic MAC array: streams buffered operands to the
// array driver, requests a drain, and captures the results into a read buffer.
module systolic_host
  import systolic_pkg::*;
#(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned steps_p        = 2,
  localparam int unsigned Ops     = ops_f(array_width_p, array_height_p, steps_p),
  localparam int unsigned Macs    = macs_f(array_width_p, array_height_p),
  localparam int unsigned WrAddrW = clog2_min1_f(Ops),
  localparam int unsigned RdAddrW = clog2_min1_f(Macs)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               wr_en_i,
  input  logic [WrAddrW-1:0] wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,
  input  logic               start_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               flush_o,
  input  logic               valid_i,
  output logic               yumi_o,
  input  logic [width_p-1:0] data_i,
  input  logic [RdAddrW-1:0] rd_addr_i,
  output logic [width_p-1:0] rd_data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned BeatW = $clog2(Ops + 1);
  localparam int unsigned IdxW  = $clog2(Macs + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ops - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(Macs - 1);
  localparam logic [IdxW-1:0]  MacsCnt  = IdxW'(Macs);

  logic [width_p-1:0] operand_q [Ops];
  logic [width_p-1:0] result_q  [Macs];

  state_e state_q, state_d;
  logic   valid_q, flush_q, busy_q, done_q;

  logic [BeatW-1:0] beat;
  logic [IdxW-1:0]  idx;
  logic             host_phase, job_start, beat_hs, yumi;

  assign host_phase = (state_q == StIdle) || (state_q == StDone);
  assign job_start  = en_i && start_i && host_phase;
  assign beat_hs    = en_i && (state_q == StStream) && ready_i;
  assign yumi       = en_i && (state_q == StCollect) && valid_i && (idx < MacsCnt);

  systolic_host_counter #(
    .Width  (BeatW),
    .MaxVal (Ops)
  ) u_beat_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (en_i),
    .clr_i     (job_start),
    .inc_i     (beat_hs),
    .count_o   (beat)
  );

  systolic_host_counter #(
    .Width  (IdxW),
    .MaxVal (Macs)
  ) u_idx_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (en_i),
    .clr_i     (job_start),
    .inc_i     (yumi),
    .count_o   (idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start_i) state_d = StStream;
      StStream:       if (ready_i && (beat == LastBeat)) state_d = StWaitBusy;
      StWaitBusy:     if (!ready_i) state_d = StWaitIdle;
      StWaitIdle:     if (ready_i) state_d = StFlush;
      StFlush:        state_d = StCollect;
      StCollect:      if (yumi && (idx == LastIdx)) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(Macs); i++) result_q[i] <= '0;
    end else if (en_i) begin
      state_q <= state_d;
      valid_q <= (state_d == StStream);
      flush_q <= (state_d == StFlush);
      busy_q  <= !((state_d == StIdle) || (state_d == StDone));
      done_q  <= (state_d == StDone);
      if (yumi) result_q[idx[RdAddrW-1:0]] <= data_i;
    end
  end

  // Operand buffer survives reset so a job can be rerun without reloading.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && en_i && wr_en_i && host_phase && (32'(wr_addr_i) < Ops)) begin
      operand_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign valid_o   = valid_q;
  assign flush_o   = flush_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign yumi_o    = yumi;
  assign data_o    = valid_q ? operand_q[beat[WrAddrW-1:0]] : '0;
  assign rd_data_o = (32'(rd_addr_i) < Macs) ? result_q[rd_addr_i] : '0;

endmodule

// File: tb/tb_systolic_host.sv
// Directed-sequence bench for systolic_host with random operand/result data
// checked against an array model of the operand and result buffers.
module tb_systolic_host;

  localparam int unsigned W    = 32;
  localparam int unsigned OPS  = 8;
  localparam int unsigned MACS = 4;

  logic         clk = 1'b0;
  logic         reset_n, en, wr_en, start, ready, valid_in;
  logic [2:0]   wr_addr;
  logic [1:0]   rd_addr;
  logic [W-1:0] wr_data, data_in;
  logic         valid_out, flush, yumi, busy, done;
  logic [W-1:0] data_out, rd_data;

  int total  = 0;
  int passed = 0;

  logic [W-1:0] m_op  [OPS];
  logic [W-1:0] m_res [MACS];

  always #5 clk = ~clk;

  systolic_host dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .en_i      (en),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .start_i   (start),
    .valid_o   (valid_out),
    .ready_i   (ready),
    .data_o    (data_out),
    .flush_o   (flush),
    .valid_i   (valid_in),
    .yumi_o    (yumi),
    .data_i    (data_in),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .busy_o    (busy),
    .done_o    (done)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results();
    for (int a = 0; a < int'(MACS); a++) begin
      rd_addr = 2'(a);
      #1;
      chk("rd_data", rd_data, m_res[a]);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk_b({tag, "_valid"}, valid_out, 1'b0);
    chk_b({tag, "_flush"}, flush, 1'b0);
    chk_b({tag, "_yumi"}, yumi, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
  endtask

  task automatic write_ops(input bit rnd);
    for (int i = 0; i < int'(OPS); i++) begin
      logic [W-1:0] v;
      v        = rnd ? $urandom : W'(i + 1);
      wr_en    = 1'b1;
      wr_addr  = 3'(i);
      wr_data  = v;
      m_op[i]  = v;
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_job();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready toggles every cycle.
  task automatic stream(input int mode, input int stop_at, input int hold_at);
    int got  = 0;
    int c    = 0;
    bit held = 1'b0;
    while (got < stop_at && c < 200) begin
      if (got == hold_at && !held) begin
        held  = 1'b1;
        en    = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          #1;
          chk_b("hold_valid", valid_out, 1'b1);
          chk("hold_data", data_out, m_op[got]);
          chk_b("hold_busy", busy, 1'b1);
          cyc();
        end
        en = 1'b1;
      end
      ready = (mode == 0) ? 1'b1 : 1'(c % 2);
      #1;
      chk_b("stream_valid", valid_out, 1'b1);
      chk("stream_data", data_out, m_op[got]);
      chk_b("stream_busy", busy, 1'b1);
      if (ready) got++;
      cyc();
      c++;
    end
    ready = 1'b0;
    chk("stream_beats", W'(got), W'(stop_at));
    if (mode == 0 && hold_at < 0) chk("stream_cycles", W'(c), W'(stop_at));
  endtask

  task automatic drain();
    int flushes = 0;
    for (int i = 0; i < 3; i++) begin
      ready = 1'b0;
      #1;
      chk_b("drain_valid", valid_out, 1'b0);
      chk_b("drain_flush", flush, 1'b0);
      chk_b("drain_busy", busy, 1'b1);
      cyc();
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (flush) flushes++;
      chk_b("drain_valid_hi", valid_out, 1'b0);
      cyc();
    end
    chk("flush_pulses", W'(flushes), W'(1));
  endtask

  task automatic collect(input bit rnd, input bit ignore_test);
    if (ignore_test) begin
      start    = 1'b1;
      wr_en    = 1'b1;
      wr_addr  = 3'd0;
      wr_data  = ~m_op[0];
      valid_in = 1'b0;
      #1;
      chk_b("ign_yumi", yumi, 1'b0);
      cyc();
      start = 1'b0;
      wr_en = 1'b0;
      #1;
      chk_b("ign_busy", busy, 1'b1);
      chk_b("ign_done", done, 1'b0);
    end
    for (int k = 0; k < int'(MACS); k++) begin
      logic [W-1:0] v;
      v        = rnd ? $urandom : W'((k + 1) * 10);
      valid_in = 1'b1;
      data_in  = v;
      #1;
      chk_b("collect_yumi", yumi, 1'b1);
      chk_b("collect_done", done, 1'b0);
      cyc();
      m_res[k] = v;
    end
    valid_in = 1'b0;
    #1;
    chk_b("job_done", done, 1'b1);
    chk_b("job_busy", busy, 1'b0);
    check_results();
    if (ignore_test) begin
      valid_in = 1'b1;
      data_in  = 32'hdead_beef;
      #1;
      chk_b("extra_yumi", yumi, 1'b0);
      cyc();
      valid_in = 1'b0;
      #1;
      chk_b("extra_done", done, 1'b1);
      check_results();
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start    = 1'b0;
    ready    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    rd_addr  = '0;
    for (int i = 0; i < int'(MACS); i++) m_res[i] = '0;
    cyc();
    cyc();
    #1;
    check_quiet("reset");
    check_results();
    reset_n = 1'b1;

    // Nominal job: operands 1..8, results 10..40.
    write_ops(1'b0);
    start_job();
    stream(0, OPS, -1);
    drain();
    collect(1'b0, 1'b0);

    // Backpressure with random operands, plus ignored start/write/extra result.
    write_ops(1'b1);
    start_job();
    stream(1, OPS, -1);
    drain();
    collect(1'b1, 1'b1);

    // Enable held low for 4 cycles at beat 3.
    start_job();
    stream(0, OPS, 3);
    drain();
    collect(1'b1, 1'b0);

    // Reset at beat 5, then a fresh job restarts from the first operand.
    start_job();
    stream(0, 5, -1);
    reset_n = 1'b0;
    cyc();
    #1;
    check_quiet("midreset");
    for (int i = 0; i < int'(MACS); i++) m_res[i] = '0;
    check_results();
    reset_n = 1'b1;
    start_job();
    stream(0, OPS, -1);
    drain();
    collect(1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
